// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end of the pipelined RV32I core. Owns the program
// counter, issues word reads to a synchronous instruction memory with a
// one-cycle read latency, and hands {pc, insn} beats to decode. A one-entry
// skid buffer catches the response that is already in flight when decode
// stalls, so a stall never loses a fetched word.
//
// Ports:
//   clock           sole clock, all state updates on posedge
//   reset           synchronous, active-high
//   imem_req        read request this cycle
//   imem_addr       word-aligned byte address of the request (pc)
//   imem_rdata      read data, valid the cycle after imem_req
//   f_valid         beat valid to decode
//   f_pc, f_insn    pc and instruction of the beat
//   f_ready         decode can take the beat
//   redirect_valid  control-flow redirect from execute
//   redirect_pc     redirect target, low two bits ignored
//
// Handshake: a beat transfers on a rising edge where f_valid && f_ready.
// Once f_valid is high it stays high, and f_pc/f_insn stay stable, until the
// transfer happens; only reset or a redirect withdraws an unaccepted beat.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] PC_RESET = 32'h0100_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              f_valid,
    output logic [AWIDTH-1:0] f_pc,
    output logic [31:0]       f_insn,
    input  logic              f_ready,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [AWIDTH-1:0] pc;
    logic              pend;       // a response arrives on imem_rdata this cycle
    logic [AWIDTH-1:0] req_pc;     // pc belonging to that response
    logic              skid_valid;
    logic [AWIDTH-1:0] skid_pc;
    logic [31:0]       skid_insn;

    logic out_free;                // output register may be overwritten this cycle
    logic issue;

    always_comb begin
        out_free = !f_valid || f_ready;
        // A new request is only made if its response is certain to have a
        // home next cycle: a full skid, or a response that is about to fill
        // the skid because the output is stalled, both block issue.
        issue = !reset && !redirect_valid && !skid_valid
                && !(pend && f_valid && !f_ready);
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= PC_RESET;
            pend       <= 1'b0;
            req_pc     <= PC_RESET;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_insn  <= NOP;
            f_valid    <= 1'b0;
            f_pc       <= '0;
            f_insn     <= NOP;
        end else if (redirect_valid) begin
            // Flush: the response landing this cycle is dropped, and no
            // request was made this cycle so nothing lands next cycle.
            // A beat handshaken this cycle already belongs to decode.
            pc         <= {redirect_pc[AWIDTH-1:2], 2'b00};
            pend       <= 1'b0;
            skid_valid <= 1'b0;
            f_valid    <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + AWIDTH'(4);
            end

            if (pend) begin
                if (out_free) begin
                    f_valid <= 1'b1;
                    if (skid_valid) begin
                        // Older skid beat goes out first; new data takes its
                        // place so program order is kept.
                        f_pc      <= skid_pc;
                        f_insn    <= skid_insn;
                        skid_pc   <= req_pc;
                        skid_insn <= imem_rdata;
                    end else begin
                        f_pc   <= req_pc;
                        f_insn <= imem_rdata;
                    end
                end else begin
                    // Output stalled; skid is empty here because a stalled
                    // output with a response pending suppressed the issue
                    // that could have filled it.
                    skid_valid <= 1'b1;
                    skid_pc    <= req_pc;
                    skid_insn  <= imem_rdata;
                end
            end else if (out_free) begin
                if (skid_valid) begin
                    f_valid    <= 1'b1;
                    f_pc       <= skid_pc;
                    f_insn     <= skid_insn;
                    skid_valid <= 1'b0;
                end else begin
                    f_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_insn;
    logic        f_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    fetch_stage #(.AWIDTH(32), .PC_RESET(BASE)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_insn         (f_insn),
        .f_ready        (f_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- instruction memory: word[i] = 0x1000 + i ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 32'h1000 + (off >> 2);
    endfunction

    // Data is only meaningful the cycle after a request; otherwise poison.
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hdead_beef;
    end

    // ---------------- driver tasks ----------------
    // Ends at the negedge where reset has just been dropped, with f_ready=1.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        f_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        f_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_f_valid: got %b want 0", f_valid); end
        checks++; if (f_pc !== 32'h0) begin failures++; $display("FAIL reset_f_pc: got %h want 00000000", f_pc); end
        checks++; if (f_insn !== NOP) begin failures++; $display("FAIL reset_f_insn: got %h want %h", f_insn, NOP); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== BASE) begin failures++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, BASE); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(BASE + 32'(4 * k));
        do_reset();
        @(negedge clock);
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL stream_startup_valid: got %b want 0", f_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== BASE + 32'h4) begin
            failures++; $display("FAIL stream_second_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, BASE + 32'h4);
        end
        for (int j = 2; j < 10; j++) begin
            @(negedge clock);
            checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL stream_throughput: cycle %0d got f_valid=%b want 1", j, f_valid); end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL stream_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        exp_q.delete();
        for (int k = 0; k < 9; k++) exp_q.push_back(BASE + 32'(4 * k));
        do_reset();
        for (int j = 1; j < 15; j++) begin
            @(negedge clock);
            f_ready = !(j >= 4 && j <= 6);
            #1;
            if (j >= 4 && j <= 6) begin
                checks++;
                if (f_valid !== 1'b1 || f_pc !== BASE + 32'h8 || f_insn !== 32'h1002) begin
                    failures++; $display("FAIL stall_hold: cycle %0d got v=%b pc=%h insn=%h want v=1 pc=%h insn=00001002", j, f_valid, f_pc, f_insn, BASE + 32'h8);
                end
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: cycle %0d got imem_req=%b want 0", j, imem_req); end
            end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL stall_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL stall_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        logic [31:0] want [7];
        want = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h40, BASE + 32'h44, BASE + 32'h48, BASE + 32'h4c};
        exp_q.delete();
        foreach (want[k]) exp_q.push_back(want[k]);
        do_reset();
        for (int j = 1; j < 11; j++) begin
            @(negedge clock);
            redirect_valid = (j == 4);
            redirect_pc = BASE + 32'h42;
            #1;
            if (j == 4) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redirect_no_req: got imem_req=%b want 0", imem_req); end
            end
            if (j == 5) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== BASE + 32'h40) begin
                    failures++; $display("FAIL redirect_target_addr: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, BASE + 32'h40);
                end
            end
            if (j == 5 || j == 6) begin
                checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL redirect_bubble: cycle %0d got f_valid=%b want 0", j, f_valid); end
            end
            if (j == 7) begin
                checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL redirect_first_beat: got f_valid=%b want 1", f_valid); end
            end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL redirect_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL redirect_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        redirect_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redirect_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] e;
        logic [31:0] want [5];
        want = '{BASE, BASE + 32'h4, BASE + 32'h80, BASE + 32'h84, BASE + 32'h88};
        exp_q.delete();
        foreach (want[k]) exp_q.push_back(want[k]);
        do_reset();
        for (int j = 1; j < 9; j++) begin
            @(negedge clock);
            redirect_valid = (j == 3);
            redirect_pc = BASE + 32'h80;
            #1;
            if (j == 3) begin
                checks++; if (f_valid !== 1'b1 || f_pc !== BASE + 32'h4) begin
                    failures++; $display("FAIL redir_hs_beat_present: got v=%b pc=%h want v=1 pc=%h", f_valid, f_pc, BASE + 32'h4);
                end
            end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL redir_hs_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL redir_hs_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        redirect_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redir_hs_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_skid();
        logic [31:0] e;
        logic [31:0] want [5];
        want = '{BASE, BASE + 32'h4, BASE + 32'h100, BASE + 32'h104, BASE + 32'h108};
        exp_q.delete();
        foreach (want[k]) exp_q.push_back(want[k]);
        do_reset();
        for (int j = 1; j < 11; j++) begin
            @(negedge clock);
            f_ready = !(j == 4 || j == 5);
            redirect_valid = (j == 5);
            redirect_pc = BASE + 32'h100;
            #1;
            if (j == 6 || j == 7) begin
                checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL redir_skid_flush: cycle %0d got f_valid=%b want 0", j, f_valid); end
            end
            if (j == 8) begin
                checks++; if (f_valid !== 1'b1 || f_pc !== BASE + 32'h100) begin
                    failures++; $display("FAIL redir_skid_target: got v=%b pc=%h want v=1 pc=%h", f_valid, f_pc, BASE + 32'h100);
                end
            end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL redir_skid_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL redir_skid_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        redirect_valid = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redir_skid_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e;
        logic [31:0] want [6];
        want = '{BASE, BASE + 32'h4, BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hc};
        exp_q.delete();
        foreach (want[k]) exp_q.push_back(want[k]);
        do_reset();
        for (int j = 1; j < 13; j++) begin
            @(negedge clock);
            reset = (j == 5 || j == 6);
            f_ready = !(j >= 4 && j <= 6);
            #1;
            if (j == 6) begin
                checks++; if (f_valid !== 1'b0 || imem_req !== 1'b0) begin
                    failures++; $display("FAIL midreset_quiet: got v=%b req=%b want v=0 req=0", f_valid, imem_req);
                end
                checks++; if (f_pc !== 32'h0 || f_insn !== NOP) begin
                    failures++; $display("FAIL midreset_outputs: got pc=%h insn=%h want pc=00000000 insn=%h", f_pc, f_insn, NOP);
                end
            end
            if (j == 8) begin
                checks++; if (f_valid !== 1'b0 || imem_addr !== BASE + 32'h4) begin
                    failures++; $display("FAIL midreset_restart: got v=%b addr=%h want v=0 addr=%h", f_valid, imem_addr, BASE + 32'h4);
                end
            end
            if (f_valid && f_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL midreset_extra_beat: got pc=%h want none", f_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (f_pc !== e || f_insn !== mem_word(e)) begin
                        failures++; $display("FAIL midreset_beat: got pc=%h insn=%h want pc=%h insn=%h", f_pc, f_insn, e, mem_word(e));
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_count: got %0d missing beats want 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_handshake();
        test_redirect_skid();
        test_reset_midstream();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
